// File: rtl/zbt_addr_arbiter.sv
// ----------------------------------------------------------------------------
// zbt_addr_arbiter
//   Round-robin arbiter for the shared 19-bit ZBT address path. Four
//   requesters (video read, write-back, two DMA clients) compete for the
//   registered 4:1 address mux. One requester holds the grant for a bounded
//   burst. The arbiter drives the mux select and produces a valid/owner strobe
//   that lines up with the mux's registered output Y.
//
// Parameters
//   BURST_MAX  maximum beats per grant before a forced release (1..255)
//   MUX_LAT    pipeline depth of the downstream select mux (1..4)
//
// Ports
//   clk         system clock; all logic runs on posedge
//   reset_n     asynchronous active-low reset
//   req[3:0]    per-requester request; held high while beats remain
//   last[3:0]   final-beat marker; only the granted requester's bit matters
//   grant[3:0]  one-hot grant; a beat moves when grant[i] & req[i]
//   sel[1:0]    mux select: index of the current or most recent grantee
//   busy        high while a grant is held
//   addr_valid  mux output Y holds the address of a granted beat
//   addr_owner  requester index for the address currently on Y
// ----------------------------------------------------------------------------
module zbt_addr_arbiter #(
    parameter int unsigned BURST_MAX = 16,
    parameter int unsigned MUX_LAT   = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic [3:0] last,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       addr_valid,
    output logic [1:0] addr_owner
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;
    // A single-beat burst still needs a one-bit counter to keep widths legal.
    localparam int unsigned CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic [IDX_W-1:0] sel_nxt;
    logic             busy_nxt;

    // Delay lines that track the mux register stages.
    logic [MUX_LAT-1:0]            valid_pipe;
    logic [MUX_LAT-1:0][IDX_W-1:0] owner_pipe;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic             win_found_c;
    logic [IDX_W-1:0] win_idx_c;
    logic             beat_c;
    logic             last_beat_c;
    logic             cap_beat_c;

    // Round-robin search starting just after the last grantee. Adding 4 to
    // the 2-bit pointer wraps back to the pointer itself, so the last
    // candidate checked is the previous owner.
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            if (!win_found_c && req[ptr + IDX_W'(k)]) begin
                win_found_c = 1'b1;
                win_idx_c   = ptr + IDX_W'(k);
            end
        end
    end

    // A beat moves only while a grant is held and its owner still requests.
    always_comb begin
        beat_c      = busy && (|(grant & req));
        last_beat_c = beat_c && (|(grant & req & last));
        cap_beat_c  = beat_c && (cnt == CNT_W'(BURST_MAX - 1));
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            ptr   <= IDX_W'(N_REQ - 1);
            cnt   <= '0;
            grant <= '0;
            sel   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            grant <= grant_nxt;
            sel   <= sel_nxt;
            busy  <= busy_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and next registered outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        grant_nxt = grant;
        sel_nxt   = sel;
        busy_nxt  = busy;

        case (state)
            ST_IDLE: begin
                // The idle cycle doubles as the mux turnaround bubble.
                if (win_found_c) begin
                    state_nxt = ST_BUSY;
                    grant_nxt = N_REQ'(1) << win_idx_c;
                    sel_nxt   = win_idx_c;
                    busy_nxt  = 1'b1;
                    ptr_nxt   = win_idx_c;
                    cnt_nxt   = '0;
                end
            end

            ST_BUSY: begin
                // Release covers withdrawal, the owner's last beat and the
                // burst cap; new requests wait for the following idle cycle.
                if (!beat_c || last_beat_c || cap_beat_c) begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
                busy_nxt  = 1'b0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Valid/owner pipeline matching the mux register depth
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_pipe <= '0;
            owner_pipe <= '0;
        end else begin
            valid_pipe[0] <= beat_c;
            owner_pipe[0] <= sel;
            for (int k = 1; k < int'(MUX_LAT); k++) begin
                valid_pipe[k] <= valid_pipe[k-1];
                owner_pipe[k] <= owner_pipe[k-1];
            end
        end
    end

    assign addr_valid = valid_pipe[MUX_LAT-1];
    assign addr_owner = owner_pipe[MUX_LAT-1];

endmodule

// File: tb/tb_zbt_addr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_zbt_addr_arbiter
//   Self-checking bench for zbt_addr_arbiter with default parameters.
//   A transaction-level reference model (owner index, beat count, delay
//   queues) predicts every output each cycle. A vector table covers a
//   single burst, and short directed sequences cover reset, rotation, the
//   burst cap, withdrawal and reset in the middle of a burst.
// ----------------------------------------------------------------------------
module tb_zbt_addr_arbiter;

    localparam int BURST_MAX = 16;
    localparam int MUX_LAT   = 1;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       addr_valid;
    logic [1:0] addr_owner;

    int total;
    int bad;

    zbt_addr_arbiter #(
        .BURST_MAX(BURST_MAX),
        .MUX_LAT  (MUX_LAT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .last      (last),
        .grant     (grant),
        .sel       (sel),
        .busy      (busy),
        .addr_valid(addr_valid),
        .addr_owner(addr_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_owner;   // -1 when no grant is held
    int m_ptr;
    int m_sel;
    int m_beats;   // beats completed in the current grant
    int vq[$];     // beat history, front is what Y shows now
    int oq[$];

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 3;
        m_sel   = 0;
        m_beats = 0;
        vq.delete();
        oq.delete();
        for (int i = 0; i < MUX_LAT; i++) begin
            vq.push_back(0);
            oq.push_back(0);
        end
    endtask

    // Advance the model across one rising edge with the inputs seen there.
    task automatic model_step(input logic [3:0] r, input logic [3:0] l);
        int beat;
        beat = (m_owner >= 0 && r[m_owner]) ? 1 : 0;
        vq.push_back(beat);
        oq.push_back(m_sel);
        void'(vq.pop_front());
        void'(oq.pop_front());
        if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (m_owner < 0 && r[c]) begin
                    m_owner = c;
                    m_ptr   = c;
                    m_sel   = c;
                    m_beats = 0;
                end
            end
        end else if (beat == 0) begin
            m_owner = -1;
        end else begin
            m_beats++;
            if (l[m_owner] || m_beats == BURST_MAX) m_owner = -1;
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [3:0] eg;
        eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        chk("model grant", 8'(grant), 8'(eg));
        chk("model sel", 8'(sel), 8'(m_sel));
        chk("model busy", 8'(busy), 8'(m_owner >= 0));
        chk("model addr_valid", 8'(addr_valid), 8'(vq[0]));
        if (vq[0] != 0) chk("model addr_owner", 8'(addr_owner), 8'(oq[0]));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic [3:0] r, input logic [3:0] l);
        req  = r;
        last = l;
        @(posedge clk);
        model_step(r, l);
        #1;
        check_model();
        @(negedge clk);
    endtask

    task automatic do_reset();
        req     = 4'h0;
        last    = 4'h0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    function automatic int onehot_idx(input logic [3:0] g);
        int idx;
        idx = -1;
        for (int i = 0; i < 4; i++) if (g[i]) idx = i;
        return idx;
    endfunction

    // ---------------- single burst vector table ----------------
    typedef struct {
        logic [3:0] r;
        logic [3:0] l;
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
        logic       v;
        logic [1:0] o;
    } vec_t;

    vec_t vt[7];

    initial begin
        total = 0;
        bad   = 0;
        req   = 4'hF;
        last  = 4'h0;
        reset_n = 1'b0;
        model_reset();

        //        req    last   grant  sel    busy  valid owner
        vt[0] = '{4'h4, 4'h0, 4'h4, 2'd2, 1'b1, 1'b0, 2'd0};
        vt[1] = '{4'h4, 4'h0, 4'h4, 2'd2, 1'b1, 1'b1, 2'd2};
        vt[2] = '{4'h4, 4'h0, 4'h4, 2'd2, 1'b1, 1'b1, 2'd2};
        vt[3] = '{4'h4, 4'h0, 4'h4, 2'd2, 1'b1, 1'b1, 2'd2};
        vt[4] = '{4'h4, 4'h0, 4'h4, 2'd2, 1'b1, 1'b1, 2'd2};
        vt[5] = '{4'h4, 4'h4, 4'h0, 2'd2, 1'b0, 1'b1, 2'd2};
        vt[6] = '{4'h0, 4'h0, 4'h0, 2'd2, 1'b0, 1'b0, 2'd2};

        // ---- reset held with all requests active ----
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("reset grant", 8'(grant), 8'h0);
            chk("reset sel", 8'(sel), 8'h0);
            chk("reset busy", 8'(busy), 8'h0);
            chk("reset addr_valid", 8'(addr_valid), 8'h0);
            chk("reset addr_owner", 8'(addr_owner), 8'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        step(4'hF, 4'h0);
        chk("first grant after reset", 8'(grant), 8'h1);

        // ---- single burst from the table ----
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(vt[i].r, vt[i].l);
            chk($sformatf("vec%0d grant", i), 8'(grant), 8'(vt[i].g));
            chk($sformatf("vec%0d sel", i), 8'(sel), 8'(vt[i].s));
            chk($sformatf("vec%0d busy", i), 8'(busy), 8'(vt[i].b));
            chk($sformatf("vec%0d addr_valid", i), 8'(addr_valid), 8'(vt[i].v));
            chk($sformatf("vec%0d addr_owner", i), 8'(addr_owner), 8'(vt[i].o));
        end

        // ---- round robin, last on every second beat ----
        begin
            int order[$];
            int exp_order[5];
            logic [3:0] prev_g;
            logic [3:0] l;
            exp_order = '{0, 1, 2, 3, 0};
            do_reset();
            prev_g = 4'h0;
            for (int c = 0; c < 80 && order.size() < 5; c++) begin
                l = (m_owner >= 0 && m_beats == 1) ? (4'b0001 << m_owner) : 4'h0;
                step(4'hF, l);
                if (grant != 4'h0 && prev_g == 4'h0) order.push_back(onehot_idx(grant));
                prev_g = grant;
            end
            chk("rr grant count", 8'(order.size()), 8'd5);
            for (int i = 0; i < 5; i++) begin
                if (i < order.size())
                    chk($sformatf("rr order%0d", i), 8'(order[i]), 8'(exp_order[i]));
            end
        end

        // ---- burst cap with another request pending ----
        begin
            int ncyc;
            int guard;
            do_reset();
            step(4'hA, 4'h0);
            chk("cap first grant", 8'(grant), 8'h2);
            ncyc  = 1;
            guard = 0;
            while (grant != 4'h0 && guard < 40) begin
                step(4'hA, 4'h0);
                if (grant == 4'h2) ncyc++;
                guard++;
            end
            chk("cap grant cycles", 8'(ncyc), 8'(BURST_MAX));
            chk("cap bubble", 8'(grant), 8'h0);
            step(4'hA, 4'h0);
            chk("cap next grant", 8'(grant), 8'h8);
            // requester 3 withdraws; only requester 1 is left
            step(4'h2, 4'h0);
            chk("cap release", 8'(grant), 8'h0);
            step(4'h2, 4'h0);
            chk("cap back to 1", 8'(grant), 8'h2);
        end

        // ---- withdraw after three beats ----
        begin
            int pulses;
            int badown;
            do_reset();
            step(4'h8, 4'h0);
            chk("wd grant", 8'(grant), 8'h8);
            pulses = 0;
            badown = 0;
            for (int i = 0; i < 3; i++) begin
                step(4'h8, 4'h0);
                if (addr_valid) begin
                    pulses++;
                    if (addr_owner != 2'd3) badown++;
                end
            end
            step(4'h0, 4'h0);
            chk("wd grant falls", 8'(grant), 8'h0);
            for (int i = 0; i < 4; i++) begin
                if (addr_valid) begin
                    pulses++;
                    if (addr_owner != 2'd3) badown++;
                end
                step(4'h0, 4'h0);
            end
            chk("wd valid pulses", 8'(pulses), 8'd3);
            chk("wd owner errors", 8'(badown), 8'd0);
        end

        // ---- reset during the fourth beat of a burst ----
        begin
            int stale;
            do_reset();
            step(4'h1, 4'h0);
            for (int i = 0; i < 3; i++) step(4'h1, 4'h0);
            chk("mr busy before", 8'(busy), 8'h1);
            #2;
            reset_n = 1'b0;
            req     = 4'h0;
            #1;
            chk("mr grant async", 8'(grant), 8'h0);
            chk("mr busy async", 8'(busy), 8'h0);
            chk("mr addr_valid async", 8'(addr_valid), 8'h0);
            chk("mr sel async", 8'(sel), 8'h0);
            @(negedge clk);
            @(negedge clk);
            reset_n = 1'b1;
            model_reset();
            stale = 0;
            for (int i = 0; i < 4; i++) begin
                step(4'h0, 4'h0);
                if (addr_valid) stale++;
            end
            chk("mr stale valid", 8'(stale), 8'd0);
        end

        // ---- randomized traffic against the model ----
        begin
            logic [3:0] r;
            logic [3:0] l;
            do_reset();
            r = 4'h0;
            for (int c = 0; c < 3000; c++) begin
                for (int i = 0; i < 4; i++)
                    if ($urandom_range(0, 4) == 0) r[i] = ~r[i];
                l = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
                step(r, l);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
